round_key_sequencer: RTL and testbench

Initiator side of the Key_Scheduler round-key interface. It enables expansion, waits for Ry, then drives SelKey through rounds 0..NUM_ROUNDS for encryption or NUM_ROUNDS..0 for decryption. It captures each Key after a settle delay and hands it to the round datapath over a valid/ready handshake. It sits between Key_Scheduler and the AES cipher/inverse-cipher controllers.

---
 rtl/round_key_sequencer_if.sv | 32 +++
 rtl/round_key_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_round_key_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/round_key_sequencer_if.sv
// Round-key sequencer bus: control, Key_Scheduler link and round-key output channel.
// Latency: n/a (signal bundle only).
// Backpressure: RkValid/RkReady handshake on the round-key channel.
//
// master : the sequencer (drives KsEn/KsSelKey, RkKey/RkIdx/RkValid/RkLast, Busy/Done/Err)
// slave  : the environment (drives Start/Dir, KsKey/KsRy, RkReady)
interface round_key_sequencer_if;
    logic         Start;
    logic         Dir;
    logic         KsEn;
    logic [3:0]   KsSelKey;
    logic [127:0] KsKey;
    logic         KsRy;
    logic [127:0] RkKey;
    logic [3:0]   RkIdx;
    logic         RkValid;
    logic         RkReady;
    logic         RkLast;
    logic         Busy;
    logic         Done;
    logic         Err;

    modport master (
        input  Start, Dir, KsKey, KsRy, RkReady,
        output KsEn, KsSelKey, RkKey, RkIdx, RkValid, RkLast, Busy, Done, Err
    );

    modport slave (
        output Start, Dir, KsKey, KsRy, RkReady,
        input  KsEn, KsSelKey, RkKey, RkIdx, RkValid, RkLast, Busy, Done, Err
    );
endinterface

// File: rtl/round_key_sequencer.sv
// Walks Key_Scheduler SelKey through rounds 0..NUM_ROUNDS (or reverse), captures each Key, presents it downstream.
// Latency: first key SEL_SETTLE clocks after KsRy-driven select; one key per SEL_SETTLE+1 clocks with RkReady held.
// Backpressure: RkKey/RkIdx/RkLast hold with RkValid until RkReady; KsRy loss returns to EXPAND, same round.
//
// Ports: Clk (rising edge), Rst (async, active-low), bus (round_key_sequencer_if.master).
// Optional build macro KEY_RETAIN_EN: keep KsEn high after the first expansion and skip
// EXPAND on Start when KsRy is already high.
module round_key_sequencer #(
    parameter int NUM_ROUNDS = 10,
    parameter int SEL_SETTLE = 2,
    parameter int RY_TIMEOUT = 255
) (
    input  logic                  Clk,
    input  logic                  Rst,
    round_key_sequencer_if.master bus
);
    localparam int TMO_W = $clog2(RY_TIMEOUT + 1);
    localparam int SET_W = (SEL_SETTLE > 1) ? $clog2(SEL_SETTLE) : 1;

    localparam logic [3:0]       LAST_UP = 4'(NUM_ROUNDS);
    localparam logic [TMO_W-1:0] TMO_END = TMO_W'(RY_TIMEOUT - 1);
    localparam logic [SET_W-1:0] SET_END = SET_W'(SEL_SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_SELECT,
        ST_PRESENT,
        ST_DONE
    } state_t;

    state_t             state_q,   state_d;
    logic               dir_q,     dir_d;
    logic [3:0]         idx_q,     idx_d;
    logic [TMO_W-1:0]   tmo_q,     tmo_d;
    logic [SET_W-1:0]   set_q,     set_d;
    logic               ks_en_q,   ks_en_d;
    logic [3:0]         sel_q,     sel_d;
    logic [127:0]       rk_key_q,  rk_key_d;
    logic [3:0]         rk_idx_q,  rk_idx_d;
    logic               rk_vld_q,  rk_vld_d;
    logic               rk_last_q, rk_last_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               err_q,     err_d;
`ifdef KEY_RETAIN_EN
    logic               retain_q,  retain_d;
`endif

    logic               ks_en_rest;   // KsEn level outside an active sequence
    logic [3:0]         start_idx;
    logic [3:0]         idx_step;
    logic               is_last;
    logic               xfer;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        set_d     = set_q;
        ks_en_d   = ks_en_q;
        sel_d     = sel_q;
        rk_key_d  = rk_key_q;
        rk_idx_d  = rk_idx_q;
        rk_vld_d  = rk_vld_q;
        rk_last_d = rk_last_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
`ifdef KEY_RETAIN_EN
        retain_d   = retain_q;
        ks_en_rest = retain_q;
`else
        ks_en_rest = 1'b0;
`endif
        start_idx = bus.Dir ? LAST_UP : 4'd0;
        idx_step  = dir_q ? (idx_q - 4'd1) : (idx_q + 4'd1);
        is_last   = dir_q ? (idx_q == 4'd0) : (idx_q == LAST_UP);
        xfer      = rk_vld_q & bus.RkReady;

        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    dir_d   = bus.Dir;
                    idx_d   = start_idx;
                    ks_en_d = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_EXPAND;
`ifdef KEY_RETAIN_EN
                    // Schedule is still expanded from a previous run: go straight to selection.
                    if (retain_q && bus.KsRy) begin
                        sel_d   = start_idx;
                        set_d   = '0;
                        state_d = ST_SELECT;
                    end
`endif
                end
            end
            ST_EXPAND: begin
                if (bus.KsRy) begin
                    sel_d   = idx_q;
                    set_d   = '0;
                    state_d = ST_SELECT;
`ifdef KEY_RETAIN_EN
                    retain_d = 1'b1;
`endif
                end else if (tmo_q == TMO_END) begin
                    // Err rises on the RY_TIMEOUT-th edge after entering EXPAND.
                    err_d   = 1'b1;
                    ks_en_d = ks_en_rest;
                    tmo_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_SELECT: begin
                if (!bus.KsRy) begin
                    tmo_d   = '0;
                    state_d = ST_EXPAND;
                end else if (set_q == SET_END) begin
                    rk_key_d  = bus.KsKey;
                    rk_idx_d  = idx_q;
                    rk_vld_d  = 1'b1;
                    rk_last_d = is_last;
                    state_d   = ST_PRESENT;
                end else begin
                    set_d = set_q + 1'b1;
                end
            end
            ST_PRESENT: begin
                if (xfer) begin
                    // A transfer wins over a simultaneous KsRy loss: advance first.
                    rk_vld_d  = 1'b0;
                    rk_last_d = 1'b0;
                    if (rk_last_q) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_step;
                        sel_d   = idx_step;
                        set_d   = '0;
                        tmo_d   = '0;
                        state_d = bus.KsRy ? ST_SELECT : ST_EXPAND;
                    end
                end else if (!bus.KsRy) begin
                    rk_vld_d  = 1'b0;
                    rk_last_d = 1'b0;
                    tmo_d     = '0;
                    state_d   = ST_EXPAND;
                end
            end
            ST_DONE: begin
                ks_en_d = ks_en_rest;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= ST_IDLE;
            dir_q     <= 1'b0;
            idx_q     <= '0;
            tmo_q     <= '0;
            set_q     <= '0;
            ks_en_q   <= 1'b0;
            sel_q     <= '0;
            rk_key_q  <= '0;
            rk_idx_q  <= '0;
            rk_vld_q  <= 1'b0;
            rk_last_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef KEY_RETAIN_EN
            retain_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            set_q     <= set_d;
            ks_en_q   <= ks_en_d;
            sel_q     <= sel_d;
            rk_key_q  <= rk_key_d;
            rk_idx_q  <= rk_idx_d;
            rk_vld_q  <= rk_vld_d;
            rk_last_q <= rk_last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef KEY_RETAIN_EN
            retain_q  <= retain_d;
`endif
        end
    end

    assign bus.KsEn     = ks_en_q;
    assign bus.KsSelKey = sel_q;
    assign bus.RkKey    = rk_key_q;
    assign bus.RkIdx    = rk_idx_q;
    assign bus.RkValid  = rk_vld_q;
    assign bus.RkLast   = rk_last_q;
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.Err      = err_q;
endmodule

// File: tb/tb_round_key_sequencer.sv
// Bench for round_key_sequencer: Key_Scheduler responder, transfer scoreboard, directed + random runs.
// Latency: n/a.
// Backpressure: RkReady driven directly and randomly.
module tb_round_key_sequencer;
    localparam int NUM_ROUNDS = 10;
    localparam int SEL_SETTLE = 2;
    localparam int RY_TIMEOUT = 255;

    logic Clk = 1'b0;
    logic Rst = 1'b0;

    round_key_sequencer_if bus();

    round_key_sequencer #(
        .NUM_ROUNDS(NUM_ROUNDS),
        .SEL_SETTLE(SEL_SETTLE),
        .RY_TIMEOUT(RY_TIMEOUT)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    initial forever #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    logic [127:0] ks_table [16];
    int  ry_lat  = 3;
    bit  ry_kill = 1'b0;
    bit  ry_block = 1'b0;

    int pcyc = 0;
    logic [3:0]   tr_idx  [$];
    logic [127:0] tr_key  [$];
    logic         tr_last [$];
    int           tr_cyc  [$];
    int done_cnt = 0;
    int err_cnt  = 0;
    int err_pc   = 0;
    int vld_cnt  = 0;
    int first_vld_pc = 0;

    // Key_Scheduler stand-in: Ry rises ry_lat clocks after En, Key follows SelKey.
    initial begin : ks_model
        int  cnt;
        bit  on;
        cnt = 0;
        on  = 1'b0;
        bus.KsRy  = 1'b0;
        bus.KsKey = '0;
        forever begin
            @(posedge Clk);
            #2;
            if (!bus.KsEn) begin
                cnt = 0;
                on  = 1'b0;
            end else if (!on) begin
                if (cnt >= ry_lat) on = 1'b1;
                else cnt++;
            end
            bus.KsRy  = on && !ry_kill && !ry_block;
            bus.KsKey = ks_table[bus.KsSelKey];
        end
    end

    initial forever begin
        @(posedge Clk);
        pcyc++;
    end

    // Transfers are recorded at the negedge before the edge that completes them.
    initial forever begin
        @(negedge Clk);
        if (Rst && bus.RkValid && bus.RkReady) begin
            tr_idx.push_back(bus.RkIdx);
            tr_key.push_back(bus.RkKey);
            tr_last.push_back(bus.RkLast);
            tr_cyc.push_back(pcyc);
        end
        if (bus.Done) done_cnt++;
        if (bus.Err) begin
            err_cnt++;
            err_pc = pcyc;
        end
        if (bus.RkValid) begin
            if (vld_cnt == 0) first_vld_pc = pcyc;
            vld_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic clear_sb();
        tr_idx.delete();
        tr_key.delete();
        tr_last.delete();
        tr_cyc.delete();
        done_cnt = 0;
        err_cnt  = 0;
        vld_cnt  = 0;
    endtask

    task automatic start_seq(input bit dir);
        bus.Start = 1'b1;
        bus.Dir   = dir;
        tick();
        bus.Start = 1'b0;
    endtask

    task automatic wait_sel(input logic [3:0] v, input string tag);
        int n = 0;
        while (bus.KsSelKey !== v && n < 500) begin
            tick();
            n++;
        end
        chk($sformatf("%s_reach_sel%0d", tag, v), (n < 500), 1);
    endtask

    task automatic wait_vld(input string tag);
        int n = 0;
        while (bus.RkValid !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        chk($sformatf("%s_reach_valid", tag), (n < 500), 1);
    endtask

    // rnd: random RkReady and occasional one-clock KsRy drops
    task automatic wait_done(input string tag, input int budget, input bit rnd);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            if (rnd) begin
                bus.RkReady = ($urandom_range(0, 3) != 0);
                ry_kill     = ($urandom_range(0, 15) == 0);
            end
            tick();
            n++;
        end
        ry_kill     = 1'b0;
        bus.RkReady = 1'b1;
        chk($sformatf("%s_done_in_budget", tag), (n < budget), 1);
    endtask

    // Expected order: 0..NUM_ROUNDS ascending or NUM_ROUNDS..0 descending, each key from the table.
    task automatic check_seq(input bit dir, input string tag);
        chk($sformatf("%s_count", tag), tr_idx.size(), NUM_ROUNDS + 1);
        for (int i = 0; i < tr_idx.size() && i <= NUM_ROUNDS; i++) begin
            int e;
            e = dir ? (NUM_ROUNDS - i) : i;
            chk($sformatf("%s_idx[%0d]", tag, i), tr_idx[i], e);
            chk($sformatf("%s_key[%0d]", tag, i), tr_key[i], ks_table[e]);
            chk($sformatf("%s_last[%0d]", tag, i), tr_last[i], (i == NUM_ROUNDS));
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_KsEn"},     bus.KsEn,     0);
        chk({tag, "_KsSelKey"}, bus.KsSelKey, 0);
        chk({tag, "_RkKey"},    bus.RkKey,    0);
        chk({tag, "_RkIdx"},    bus.RkIdx,    0);
        chk({tag, "_RkValid"},  bus.RkValid,  0);
        chk({tag, "_RkLast"},   bus.RkLast,   0);
        chk({tag, "_Busy"},     bus.Busy,     0);
        chk({tag, "_Done"},     bus.Done,     0);
        chk({tag, "_Err"},      bus.Err,      0);
    endtask

    initial begin : stim
        int s;
        bit d;
        logic exp_ks_en_after;
`ifdef KEY_RETAIN_EN
        exp_ks_en_after = 1'b1;
`else
        exp_ks_en_after = 1'b0;
`endif
        bus.Start   = 1'b0;
        bus.Dir     = 1'b0;
        bus.RkReady = 1'b0;
        for (int i = 0; i < 16; i++)
            ks_table[i] = {$urandom, $urandom, $urandom, $urandom};
        ks_table[0]  = 128'he6fad5a0c3ecf681b31e5d8e3aa15916;
        ks_table[3]  = 128'hbcc778a30cf2ccb35355e46c20c202f6;
        ks_table[4]  = 128'hd91e66c55cae62d11144a0cc2ae8ea1c;
        ks_table[5]  = 128'hf7e98f4a17b9db0a8dc969a58c648e92;
        ks_table[10] = 128'h03c18e199ba5296289328eca914a59aa;
        ry_lat = $urandom_range(1, 8);

        // Reset state
        tick(3);
        check_idle_zero("reset");
        Rst = 1'b1;
        tick(2);

        // Timeout: Ry never rises
        clear_sb();
        ry_block = 1'b1;
        s = pcyc;
        start_seq(1'b0);
        begin
            int n = 0;
            while (err_cnt == 0 && n < 400) begin
                tick();
                n++;
            end
            chk("tmo_err_seen", (n < 400), 1);
        end
        chk("tmo_err_delay", err_pc - s, RY_TIMEOUT + 1);
        tick(3);
        chk("tmo_err_once", err_cnt, 1);
        chk("tmo_ks_en", bus.KsEn, 0);
        chk("tmo_busy", bus.Busy, 0);
        chk("tmo_no_valid", vld_cnt, 0);
        chk("tmo_no_done", done_cnt, 0);
        ry_block = 1'b0;

        // Ascending, RkReady held; Start in the DONE cycle must be ignored
        clear_sb();
        bus.RkReady = 1'b1;
        start_seq(1'b0);
        begin
            int n = 0;
            while (bus.Done !== 1'b1 && n < 500) begin
                tick();
                n++;
            end
            chk("asc_done_seen", (n < 500), 1);
        end
        bus.Start = 1'b1;
        bus.Dir   = 1'b0;
        tick();
        bus.Start = 1'b0;
        tick(5);
        chk("asc_busy_after", bus.Busy, 0);
        chk("asc_ks_en_after", bus.KsEn, exp_ks_en_after);
        chk("asc_done_once", done_cnt, 1);
        check_seq(1'b0, "asc");
        chk("asc_first_key", tr_key[0], 128'he6fad5a0c3ecf681b31e5d8e3aa15916);
        chk("asc_key5", tr_key[5], 128'hf7e98f4a17b9db0a8dc969a58c648e92);
        chk("asc_key10", tr_key[10], 128'h03c18e199ba5296289328eca914a59aa);
        chk("asc_last10", tr_last[10], 1);
        for (int i = 1; i < tr_cyc.size(); i++)
            chk($sformatf("asc_spacing[%0d]", i), tr_cyc[i] - tr_cyc[i-1], SEL_SETTLE + 1);

        // Descending
        clear_sb();
        bus.RkReady = 1'b1;
        start_seq(1'b1);
        wait_done("desc", 500, 1'b0);
        tick(3);
        check_seq(1'b1, "desc");
        chk("desc_first_idx", tr_idx[0], 10);
        chk("desc_first_key", tr_key[0], 128'h03c18e199ba5296289328eca914a59aa);
        chk("desc_last_key", tr_key[10], 128'he6fad5a0c3ecf681b31e5d8e3aa15916);
        chk("desc_last_flag", tr_last[10], 1);
        chk("desc_done_once", done_cnt, 1);
        for (int i = 1; i < tr_cyc.size(); i++)
            chk($sformatf("desc_spacing[%0d]", i), tr_cyc[i] - tr_cyc[i-1], SEL_SETTLE + 1);

        // Backpressure at idx3, with a Start while busy
        clear_sb();
        bus.RkReady = 1'b1;
        start_seq(1'b0);
        wait_sel(4'd3, "bp");
        bus.RkReady = 1'b0;
        wait_vld("bp");
        for (int i = 0; i < 20; i++) begin
            bus.Start = (i == 5);
            bus.Dir   = 1'b1;
            tick();
            chk($sformatf("bp_valid[%0d]", i), bus.RkValid, 1);
            chk($sformatf("bp_key[%0d]", i), bus.RkKey, 128'hbcc778a30cf2ccb35355e46c20c202f6);
            chk($sformatf("bp_idx[%0d]", i), bus.RkIdx, 3);
        end
        bus.Start   = 1'b0;
        bus.RkReady = 1'b1;
        wait_done("bp", 500, 1'b0);
        tick(3);
        check_seq(1'b0, "bp");
        chk("bp_done_once", done_cnt, 1);

        // Key loss while presenting idx4
        clear_sb();
        bus.RkReady = 1'b1;
        start_seq(1'b0);
        wait_sel(4'd4, "fault");
        bus.RkReady = 1'b0;
        wait_vld("fault");
        chk("fault_idx_before", bus.RkIdx, 4);
        ry_kill = 1'b1;
        tick();
        chk("fault_valid_drop", bus.RkValid, 0);
        chk("fault_last_drop", bus.RkLast, 0);
        chk("fault_busy", bus.Busy, 1);
        chk("fault_ks_en", bus.KsEn, 1);
        tick(3);
        ry_kill     = 1'b0;
        bus.RkReady = 1'b1;
        wait_done("fault", 500, 1'b0);
        tick(3);
        check_seq(1'b0, "fault");
        chk("fault_resume_key4", tr_key[4], 128'hd91e66c55cae62d11144a0cc2ae8ea1c);

        // Random direction, Ry latency, RkReady and brief key losses
        for (int r = 0; r < 4; r++) begin
            clear_sb();
            d = 1'($urandom_range(0, 1));
            ry_lat = $urandom_range(0, 10);
            bus.RkReady = 1'b0;
            start_seq(d);
            wait_done($sformatf("rnd%0d", r), 3000, 1'b1);
            tick(3);
            check_seq(d, $sformatf("rnd%0d", r));
            chk($sformatf("rnd%0d_done_once", r), done_cnt, 1);
        end

        // Reset in the middle of a sequence at idx7
        clear_sb();
        bus.RkReady = 1'b1;
        start_seq(1'b0);
        wait_sel(4'd7, "rst");
        Rst = 1'b0;
        #1;
        check_idle_zero("rst_mid");
        tick(2);
        Rst = 1'b1;
        tick(5);
        chk("rst_no_done", done_cnt, 0);
        chk("rst_no_err", err_cnt, 0);
        chk("rst_busy", bus.Busy, 0);

`ifdef KEY_RETAIN_EN
        // After a completed run the schedule stays enabled; the next Start skips EXPAND
        clear_sb();
        bus.RkReady = 1'b1;
        start_seq(1'b0);
        wait_done("ret1", 500, 1'b0);
        tick(3);
        chk("ret_ks_en_kept", bus.KsEn, 1);
        clear_sb();
        s = pcyc;
        start_seq(1'b0);
        wait_vld("ret2");
        tick();
        chk("ret_first_valid_delay", first_vld_pc - s, SEL_SETTLE + 1);
        chk("ret_ks_en_during", bus.KsEn, 1);
        wait_done("ret2", 500, 1'b0);
        tick(3);
        check_seq(1'b0, "ret2");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
